// File: rtl/fetch_sequencer.sv
// Fetch controller: sequences PC loads and a single-outstanding instruction-memory
// request, and presents each fetched instruction to decode exactly once.
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH  = 24,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = 24'h000100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc_cur,
    input  logic [ADDR_WIDTH-1:0]  pc_plus4,
    output logic                   pc_load_en,
    output logic [ADDR_WIDTH-1:0]  pc_next,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   instr_ready,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr,
    input  logic                   trap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_KILL = 2'd3
    } state_t;

    state_t                   state_q,       state_d;
    logic                     imem_req_q,    imem_req_d;
    logic                     instr_valid_q, instr_valid_d;
    logic [ADDR_WIDTH-1:0]    imem_addr_q,   imem_addr_d;
    logic [INSTR_WIDTH-1:0]   instr_q,       instr_d;
    logic [ADDR_WIDTH-1:0]    instr_pc_q,    instr_pc_d;

    logic                     flush_s;
    logic [ADDR_WIDTH-1:0]    tgt_s;
    logic                     load_s;
    logic [ADDR_WIDTH-1:0]    pc_next_s;

    // Trap outranks a redirect arriving in the same cycle.
    assign flush_s = trap | redirect_valid;
    assign tgt_s   = trap ? TRAP_VECTOR : redirect_addr;

    // Next-state, datapath and PC-load decisions.
    always_comb begin
        state_d    = state_q;
        imem_addr_d = imem_addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        load_s     = 1'b0;
        pc_next_s  = pc_plus4;

        case (state_q)
            ST_IDLE: begin
                state_d     = ST_REQ;
                imem_addr_d = pc_cur;
            end
            ST_REQ: begin
                if (flush_s) begin
                    load_s    = 1'b1;
                    pc_next_s = tgt_s;
                    if (imem_ack) begin
                        imem_addr_d = tgt_s;
                        state_d     = ST_REQ;
                    end else begin
                        state_d = ST_KILL;
                    end
                end else if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = imem_addr_q;
                    load_s     = 1'b1;
                    pc_next_s  = pc_plus4;
                    state_d    = ST_HOLD;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (flush_s) begin
                    load_s      = 1'b1;
                    pc_next_s   = tgt_s;
                    imem_addr_d = tgt_s;
                    state_d     = ST_REQ;
                end else if (instr_ready) begin
                    imem_addr_d = pc_cur;
                    state_d     = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_KILL: begin
                // The stale request must still complete; the PC already holds the target.
                if (flush_s) begin
                    load_s    = 1'b1;
                    pc_next_s = tgt_s;
                    if (imem_ack) begin
                        imem_addr_d = tgt_s;
                        state_d     = ST_REQ;
                    end else begin
                        state_d = ST_KILL;
                    end
                end else if (imem_ack) begin
                    imem_addr_d = pc_cur;
                    state_d     = ST_REQ;
                end else begin
                    state_d = ST_KILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        imem_req_d    = (state_d == ST_REQ) || (state_d == ST_KILL);
        instr_valid_d = (state_d == ST_HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            imem_addr_q   <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign pc_load_en  = load_s & ~reset;
    assign pc_next     = pc_next_s;
    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC register around it.
module tb_fetch_sequencer;

    localparam int AW = 24;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] pc_cur;
    logic [AW-1:0] pc_plus4;
    logic          pc_load_en;
    logic [AW-1:0] pc_next;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          trap = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] pc_q = '0;

    fetch_sequencer #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .TRAP_VECTOR(24'h000100)) dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_plus4(pc_plus4),
        .pc_load_en(pc_load_en), .pc_next(pc_next), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .trap(trap)
    );

    always #5 clk = ~clk;

    // External PC register: loads whatever the sequencer selects.
    always @(posedge clk) begin
        if (pc_load_en) pc_q <= pc_next;
    end
    assign pc_cur   = pc_q;
    assign pc_plus4 = pc_q + 24'd4;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held with flush inputs active.
        trap = 1'b1; redirect_valid = 1'b1; redirect_addr = 24'h000300;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req",   32'(imem_req),    32'h0);
        chk("rst_addr",  32'(imem_addr),   32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", 32'(instr),       32'h0);
        chk("rst_ipc",   32'(instr_pc),    32'h0);
        chk("rst_load",  32'(pc_load_en),  32'h0);
        redirect_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("idle_flush_load", 32'(pc_load_en), 32'h0);
        tick();
        trap = 1'b0;

        // First fetch from 0, ack on the third REQ cycle.
        chk("t1_req",   32'(imem_req),    32'h1);
        chk("t1_addr",  32'(imem_addr),   32'h0);
        chk("t1_valid", 32'(instr_valid), 32'h0);
        #1;
        chk("t1_wait_load", 32'(pc_load_en), 32'h0);
        tick();
        chk("t1_addr_hold", 32'(imem_addr), 32'h0);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h00500093;
        #1;
        chk("t1_load", 32'(pc_load_en), 32'h1);
        chk("t1_next", 32'(pc_next),    32'h4);
        tick();
        imem_ack = 1'b0;
        chk("t1_valid_hi", 32'(instr_valid), 32'h1);
        chk("t1_instr",    32'(instr),       32'h00500093);
        chk("t1_ipc",      32'(instr_pc),    32'h0);

        // Decode stalls for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_load",  32'(pc_load_en),  32'h0);
            chk("hold_req",   32'(imem_req),    32'h0);
            chk("hold_valid", 32'(instr_valid), 32'h1);
            chk("hold_instr", 32'(instr),       32'h00500093);
            chk("hold_ipc",   32'(instr_pc),    32'h0);
            tick();
        end
        instr_ready = 1'b1;
        #1;
        chk("acc_load", 32'(pc_load_en), 32'h0);
        tick();
        chk("acc_valid", 32'(instr_valid), 32'h0);
        chk("acc_req",   32'(imem_req),    32'h1);
        chk("acc_addr",  32'(imem_addr),   32'h4);

        // Streaming with zero-latency ack and decode always ready.
        imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            imem_rdata = 32'h10000000 + 32'(k);
            #1;
            chk("st_addr", 32'(imem_addr),  32'h4 + 32'(4 * k));
            chk("st_load", 32'(pc_load_en), 32'h1);
            chk("st_next", 32'(pc_next),    32'h8 + 32'(4 * k));
            tick();
            chk("st_valid", 32'(instr_valid), 32'h1);
            chk("st_instr", 32'(instr),       32'h10000000 + 32'(k));
            chk("st_ipc",   32'(instr_pc),    32'h4 + 32'(4 * k));
            #1;
            chk("st_hold_load", 32'(pc_load_en), 32'h0);
            tick();
            chk("st_once", 32'(instr_valid), 32'h0);
        end
        imem_ack = 1'b0; instr_ready = 1'b0;

        // Redirect while REQ waits for memory.
        #1;
        chk("rd_wait_addr", 32'(imem_addr),  32'h10);
        chk("rd_wait_load", 32'(pc_load_en), 32'h0);
        tick();
        redirect_valid = 1'b1; redirect_addr = 24'h000200;
        #1;
        chk("rd_load", 32'(pc_load_en), 32'h1);
        chk("rd_next", 32'(pc_next),    32'h200);
        tick();
        redirect_valid = 1'b0;
        chk("rd_kill_req",  32'(imem_req),    32'h1);
        chk("rd_kill_addr", 32'(imem_addr),   32'h10);
        chk("rd_kill_valid", 32'(instr_valid), 32'h0);
        #1;
        chk("rd_kill_load", 32'(pc_load_en), 32'h0);
        tick();
        chk("rd_kill_addr2", 32'(imem_addr), 32'h10);
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1;
        chk("rd_ack_load", 32'(pc_load_en), 32'h0);
        tick();
        imem_ack = 1'b0;
        chk("rd_new_addr", 32'(imem_addr),   32'h200);
        chk("rd_new_req",  32'(imem_req),    32'h1);
        chk("rd_drop",     32'(instr_valid), 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h00000013;
        #1;
        chk("rd_f_load", 32'(pc_load_en), 32'h1);
        chk("rd_f_next", 32'(pc_next),    32'h204);
        tick();
        imem_ack = 1'b0;
        chk("rd_f_valid", 32'(instr_valid), 32'h1);
        chk("rd_f_instr", 32'(instr),       32'h00000013);
        chk("rd_f_ipc",   32'(instr_pc),    32'h200);

        // Trap and redirect together in HOLD, decode ready.
        trap = 1'b1; redirect_valid = 1'b1; redirect_addr = 24'h000300; instr_ready = 1'b1;
        #1;
        chk("tr_load", 32'(pc_load_en), 32'h1);
        chk("tr_next", 32'(pc_next),    32'h100);
        tick();
        trap = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        chk("tr_valid", 32'(instr_valid), 32'h0);
        chk("tr_addr",  32'(imem_addr),   32'h100);
        chk("tr_req",   32'(imem_req),    32'h1);

        // Redirect coinciding with ack in REQ.
        redirect_valid = 1'b1; redirect_addr = 24'h000400; imem_ack = 1'b1; imem_rdata = 32'h00000BAD;
        #1;
        chk("fa_load", 32'(pc_load_en), 32'h1);
        chk("fa_next", 32'(pc_next),    32'h400);
        tick();
        redirect_valid = 1'b0; imem_ack = 1'b0;
        chk("fa_addr",  32'(imem_addr),   32'h400);
        chk("fa_valid", 32'(instr_valid), 32'h0);

        // Back-to-back flushes: redirect into KILL, then trap while in KILL.
        redirect_valid = 1'b1; redirect_addr = 24'h000500;
        #1;
        chk("bb1_next", 32'(pc_next), 32'h500);
        tick();
        redirect_valid = 1'b0; trap = 1'b1;
        #1;
        chk("bb2_load", 32'(pc_load_en), 32'h1);
        chk("bb2_next", 32'(pc_next),    32'h100);
        tick();
        trap = 1'b0;
        chk("bb_kill_addr", 32'(imem_addr), 32'h400);
        chk("bb_kill_req",  32'(imem_req),  32'h1);

        // Asynchronous reset in the middle of KILL.
        #2;
        reset = 1'b1; imem_ack = 1'b1; trap = 1'b1;
        #1;
        chk("rk_req",   32'(imem_req),    32'h0);
        chk("rk_addr",  32'(imem_addr),   32'h0);
        chk("rk_valid", 32'(instr_valid), 32'h0);
        chk("rk_instr", 32'(instr),       32'h0);
        chk("rk_ipc",   32'(instr_pc),    32'h0);
        chk("rk_load",  32'(pc_load_en),  32'h0);
        tick();
        tick();
        chk("rk_req2", 32'(imem_req), 32'h0);
        trap = 1'b0;
        reset = 1'b0;
        #1;
        chk("rs_idle_load", 32'(pc_load_en), 32'h0);
        tick();
        imem_ack = 1'b0;
        chk("rs_req",   32'(imem_req),    32'h1);
        chk("rs_addr",  32'(imem_addr),   32'h100);
        chk("rs_valid", 32'(instr_valid), 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h00000033;
        #1;
        chk("rs_load", 32'(pc_load_en), 32'h1);
        chk("rs_next", 32'(pc_next),    32'h104);
        tick();
        imem_ack = 1'b0;
        chk("rs_instr", 32'(instr),    32'h00000033);
        chk("rs_ipc",   32'(instr_pc), 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch controller that sequences the program counter register and the instruction-memory port. It decides each cycle whether the PC loads and with what value (PC+4, branch redirect or trap vector). It issues one instruction-memory request at a time with a req/ack handshake and presents the fetched instruction to decode with a valid/ready handshake. Redirects and traps flush fetched or in-flight instructions.

Parameters:
ADDR_WIDTH, 24, width of PC and instruction address
INSTR_WIDTH, 32, instruction word width
TRAP_VECTOR, 24'h000100, PC target on trap

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pc_cur  in  ADDR_WIDTH  current PC from the PC register
pc_plus4  in  ADDR_WIDTH  PC+4 from the PC register
pc_load_en  out  1  PC load strobe, combinational
pc_next  out  ADDR_WIDTH  PC load value, combinational
imem_req  out  1  instruction-memory request
imem_addr  out  ADDR_WIDTH  request address, registered
imem_ack  in  1  memory has returned data this cycle
imem_rdata  in  INSTR_WIDTH  returned instruction
instr_valid  out  1  instruction available to decode
instr  out  INSTR_WIDTH  fetched instruction, registered
instr_pc  out  ADDR_WIDTH  address of instr, registered
instr_ready  in  1  decode accepts instr
redirect_valid  in  1  branch/jump redirect, one-cycle pulse
redirect_addr  in  ADDR_WIDTH  redirect target
trap  in  1  trap request, one-cycle pulse

Behaviour:
- States: IDLE, REQ, HOLD, KILL. Reset (async, any time) forces IDLE.
- Reset values: imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0. pc_load_en=0 while reset is high.
- Target select: trap > redirect_valid > sequential. flush = trap | redirect_valid; tgt = TRAP_VECTOR if trap, else redirect_addr.
- On flush in any state except IDLE:
  - pc_load_en=1 and pc_next=tgt in that cycle.
  - instr_valid drops the next cycle.
  - Any imem_ack in that cycle is discarded.
- IDLE: outputs inactive. Moves to REQ one cycle after reset deasserts, with imem_addr<=pc_cur. Flush in IDLE is ignored.
- REQ: imem_req=1, imem_addr held stable until ack.
  - Ack, no flush: instr<=imem_rdata, instr_pc<=imem_addr, pc_load_en=1, pc_next=pc_plus4 → HOLD.
  - Flush with ack: data discarded, imem_addr<=tgt → REQ.
  - Flush without ack: → KILL.
- KILL: imem_req stays 1 with the old imem_addr; outstanding request must complete.
  - Ack: data discarded, no PC load, imem_addr<=pc_cur (already the target) → REQ.
  - A further flush in KILL loads the new target and stays in KILL.
  - Ack and flush in the same cycle: imem_addr<=tgt → REQ.
- HOLD: instr_valid=1; instr and instr_pc stable, imem_req=0.
  - instr_ready: imem_addr<=pc_cur → REQ. Decode accepts exactly once.
  - Flush: imem_addr<=tgt → REQ, instruction dropped even if instr_ready is high.
- Throughput: at most one instruction per 2 cycles plus memory latency. One bubble in HOLD→REQ is intended.
- pc_load_en is never high in two consecutive cycles except for back-to-back flushes.
- imem_ack outside REQ/KILL is ignored.
- Address arithmetic: modulo 2^ADDR_WIDTH; wrap is done by the PC register.

Test Plan:
- Reset release, pc_cur=0x000000, ack after 2 cycles with 0x00500093 → imem_addr=0x000000; one pc_load_en pulse with pc_next=pc_plus4; instr_valid=1, instr=0x00500093, instr_pc=0x000000.
- Streaming, instr_ready held 1, zero-latency ack → fetch addresses 0x0,0x4,0x8,0xC; each instruction presented exactly once; instr_pc matches.
- instr_ready=0 for 5 cycles in HOLD → instr/instr_pc stable, imem_req=0, no PC load; accepted on the first ready cycle.
- Redirect to 0x000200 while REQ is waiting → pc_next=0x000200 that cycle; KILL keeps the old address until ack; returned data never valid; next request to 0x000200.
- trap and redirect_valid in the same cycle during HOLD → pc_next=0x000100, instr_valid=0 next cycle, next imem_addr=0x000100.
- Assert reset mid-KILL → immediately IDLE with all outputs 0; late imem_ack ignored; fetch restarts from pc_cur after release.
